// File: rtl/pulse_burst_gen.sv
// pulse_burst_gen: transmit-side burst generator for the S/X/G pulse-counting link.
// Sends one S strobe, PULSES single-cycle X pulses, then waits for the G acknowledge.
// Optional feature macro: PULSE_GAP_EN (honours the gap input and builds the GAP state).
module pulse_burst_gen #(
    parameter int unsigned PULSES  = 15,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] gap,
    input  logic       g_ack,
    output logic       s,
    output logic       x,
    output logic       busy,
    output logic       done,
    output logic       ok,
    output logic       err
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] PULSES_C  = CW'(PULSES);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_PULSE,
`ifdef PULSE_GAP_EN
        ST_GAP,
`endif
        ST_WAIT_ACK,
        ST_DONE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_pcnt;
    logic [CW-1:0]   r_tcnt;
    logic [CW-1:0]   w_pcnt_inc;
    logic [CW-1:0]   w_tcnt_inc;

`ifdef PULSE_GAP_EN
    logic [CW-1:0]   r_gcnt;
`else
    // gap has no effect without the gap feature; keep it visibly tied off
    logic            w_unused_gap;
    assign w_unused_gap = ^gap;
`endif

    assign w_pcnt_inc = r_pcnt + 4'd1;
    assign w_tcnt_inc = r_tcnt + 4'd1;

    // Burst controller: state, counters and registered outputs updated together
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pcnt  <= '0;
            r_tcnt  <= '0;
`ifdef PULSE_GAP_EN
            r_gcnt  <= '0;
`endif
            s       <= 1'b0;
            x       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ok      <= 1'b0;
            err     <= 1'b0;
        end else begin
            s    <= 1'b0;
            x    <= 1'b0;
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_ARM;
                        r_pcnt  <= '0;
                        s       <= 1'b1;
                        busy    <= 1'b1;
                        ok      <= 1'b0;
                        err     <= 1'b0;
                    end
                end
                ST_ARM: begin
                    if (g_ack) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end else begin
                        r_state <= ST_PULSE;
                        x       <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    // an acknowledge before the burst is complete is a protocol error
                    if (g_ack) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end else if (w_pcnt_inc == PULSES_C) begin
                        r_state <= ST_WAIT_ACK;
                        r_pcnt  <= w_pcnt_inc;
                        r_tcnt  <= '0;
`ifdef PULSE_GAP_EN
                    end else if (gap != 4'd0) begin
                        r_state <= ST_GAP;
                        r_pcnt  <= w_pcnt_inc;
                        r_gcnt  <= gap;
`endif
                    end else begin
                        r_pcnt  <= w_pcnt_inc;
                        x       <= 1'b1;
                    end
                end
`ifdef PULSE_GAP_EN
                ST_GAP: begin
                    if (g_ack) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end else if (r_gcnt == 4'd1) begin
                        r_state <= ST_PULSE;
                        r_gcnt  <= '0;
                        x       <= 1'b1;
                    end else begin
                        r_gcnt  <= r_gcnt - 4'd1;
                    end
                end
`endif
                ST_WAIT_ACK: begin
                    if (g_ack) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                        ok      <= 1'b1;
                    end else if (w_tcnt_inc == TIMEOUT_C) begin
                        r_state <= ST_DONE;
                        r_tcnt  <= w_tcnt_inc;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end else begin
                        r_tcnt  <= w_tcnt_inc;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
